// File: rtl/dsi_lane_feeder.sv
// DSI lane feeder: buffers packet bytes {lp,last,data} in a FIFO and hands them
// to a lane controller through a start / data-request / finish handshake.
`timescale 1ns/1ps
module dsi_lane_feeder #(
  parameter int FIFO_AW = 4
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  input  logic       s_lp,
  output logic       lines_enable,
  output logic       mode_lp,
  output logic       start_rqst,
  output logic       fin_rqst,
  output logic [7:0] inp_data,
  input  logic       data_rqst,
  input  logic       active,
  output logic       busy,
  output logic       underflow_err,
  input  logic       err_clr
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ZERO = {(FIFO_AW+1){1'b0}};
  localparam logic [FIFO_AW:0] PTR_ONE  = {{FIFO_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [9:0]       mem_r [DEPTH];
  logic [FIFO_AW:0] wr_ptr_r;
  logic [FIFO_AW:0] rd_ptr_r;
  logic [FIFO_AW:0] pkt_cnt_r;
  logic             mode_lp_r;
  logic             underflow_err_r;

  logic             full_s;
  logic             empty_s;
  logic [9:0]       head_s;
  logic             push_s;
  logic             pop_s;
  logic             underflow_s;
  logic             start_go_s;
  logic             start_rqst_s;
  logic             fin_rqst_s;
  logic [7:0]       inp_data_s;

  // Extra pointer MSB distinguishes a full FIFO from an empty one
  assign full_s  = (wr_ptr_r[FIFO_AW] != rd_ptr_r[FIFO_AW]) &&
                   (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_r[FIFO_AW-1:0]);
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign head_s  = mem_r[rd_ptr_r[FIFO_AW-1:0]];

  assign push_s      = s_valid & ~full_s;
  assign pop_s       = (state_r == SEND) & data_rqst & ~empty_s;
  assign underflow_s = (state_r == SEND) & data_rqst & empty_s;
  // A full FIFO starts the packet cut-through even before its last byte arrives
  assign start_go_s  = enable & ~empty_s & ((pkt_cnt_r != PTR_ZERO) | full_s);

  // FIFO storage write port
  always_ff @(posedge clk_sys) begin
    if (push_s) begin
      mem_r[wr_ptr_r[FIFO_AW-1:0]] <= {s_lp, s_last, s_data};
    end
  end

  // FIFO read/write pointers
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Count of complete packets held in the FIFO
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_r <= PTR_ZERO;
    end else begin
      case ({push_s & s_last, pop_s & head_s[8]})
        2'b10:   pkt_cnt_r <= pkt_cnt_r + PTR_ONE;
        2'b01:   pkt_cnt_r <= pkt_cnt_r - PTR_ONE;
        default: pkt_cnt_r <= pkt_cnt_r;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = start_go_s ? START : IDLE;
      START:   state_nxt_s = active ? SEND : START;
      SEND:    state_nxt_s = (pop_s & head_s[8]) ? DRAIN : SEND;
      DRAIN:   state_nxt_s = active ? DRAIN : IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Lane-side outputs decoded from state and FIFO head
  always_comb begin
    start_rqst_s = 1'b0;
    fin_rqst_s   = 1'b0;
    inp_data_s   = 8'h00;
    case (state_r)
      START: start_rqst_s = 1'b1;
      SEND: begin
        if (!empty_s) begin
          fin_rqst_s = head_s[8];
          inp_data_s = head_s[7:0];
        end else begin
          fin_rqst_s = 1'b0;
          inp_data_s = 8'h00;
        end
      end
      DRAIN:   fin_rqst_s = 1'b1;
      default: start_rqst_s = 1'b0;
    endcase
  end

  // Packet mode latched from the head byte as the packet is launched
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      mode_lp_r <= 1'b0;
    end else if ((state_r == IDLE) && start_go_s) begin
      mode_lp_r <= head_s[9];
    end else begin
      mode_lp_r <= mode_lp_r;
    end
  end

  // Sticky underflow flag; a new underflow wins over a clear
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      underflow_err_r <= 1'b0;
    end else if (underflow_s) begin
      underflow_err_r <= 1'b1;
    end else if (err_clr) begin
      underflow_err_r <= 1'b0;
    end else begin
      underflow_err_r <= underflow_err_r;
    end
  end

  assign s_ready       = ~full_s;
  assign busy          = (state_r != IDLE);
  assign lines_enable  = enable | (state_r != IDLE);
  assign mode_lp       = mode_lp_r;
  assign start_rqst    = start_rqst_s;
  assign fin_rqst      = fin_rqst_s;
  assign inp_data      = inp_data_s;
  assign underflow_err = underflow_err_r;

endmodule

// File: tb/tb_dsi_lane_feeder.sv
// Self-checking bench for dsi_lane_feeder: a queue of pushed entries is the
// reference; a lane model consumes bytes and checks them in order.
`timescale 1ns/1ps
module tb_dsi_lane_feeder;

  logic       clk_sys = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_lp;
  logic       lines_enable;
  logic       mode_lp;
  logic       start_rqst;
  logic       fin_rqst;
  logic [7:0] inp_data;
  logic       data_rqst;
  logic       active;
  logic       busy;
  logic       underflow_err;
  logic       err_clr;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_q[$];

  dsi_lane_feeder #(.FIFO_AW(4)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last), .s_lp(s_lp),
    .lines_enable(lines_enable), .mode_lp(mode_lp), .start_rqst(start_rqst),
    .fin_rqst(fin_rqst), .inp_data(inp_data), .data_rqst(data_rqst), .active(active),
    .busy(busy), .underflow_err(underflow_err), .err_clr(err_clr)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk_sys);
    rst_n = 1'b0;
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic push_byte(input logic lp, input logic last, input logic [7:0] d);
    int g;
    g = 0;
    s_valid = 1'b1; s_lp = lp; s_last = last; s_data = d;
    while (s_ready !== 1'b1 && g < 50) begin
      @(negedge clk_sys);
      g++;
    end
    if (g >= 50) begin
      checks++; errors++;
      $display("FAIL push_wait: s_ready=%b required 1", s_ready);
    end else begin
      exp_q.push_back({lp, last, d});
    end
    @(negedge clk_sys);
    s_valid = 1'b0;
  endtask

  task automatic push_pkt(input logic lp, input int len);
    for (int b = 0; b < len; b++) begin
      push_byte(lp, (b == len - 1) ? 1'b1 : 1'b0, 8'($urandom));
    end
  endtask

  // Lane model: serves n_pkts packets, requesting a byte every 'period' cycles
  task automatic serve(input int n_pkts, input int period, input bit push_en,
                       input logic [9:0] push_ent, input bit drop_en);
    int g;
    int cnt;
    logic [9:0] e;
    bit done;
    bit pushed;
    for (int p = 0; p < n_pkts; p++) begin
      g = 0;
      while (start_rqst !== 1'b1 && g < 300) begin
        @(negedge clk_sys);
        g++;
      end
      checks++;
      if (start_rqst !== 1'b1) begin
        errors++;
        $display("FAIL start_wait: start_rqst=%b required 1", start_rqst);
        return;
      end
      checks++;
      if (exp_q.size() == 0 || mode_lp !== exp_q[0][9]) begin
        errors++;
        $display("FAIL mode_lp: got %b required %b", mode_lp,
                 (exp_q.size() == 0) ? 1'bx : exp_q[0][9]);
      end
      checks++;
      if (inp_data !== 8'h00 || fin_rqst !== 1'b0) begin
        errors++;
        $display("FAIL start_outputs: inp_data=%h fin_rqst=%b required 00/0", inp_data, fin_rqst);
      end
      active = 1'b1;
      data_rqst = 1'b1;
      @(negedge clk_sys);
      data_rqst = 1'b0;
      if (drop_en) begin
        enable = 1'b0;
        #1;
        checks++;
        if (lines_enable !== 1'b1) begin
          errors++;
          $display("FAIL lines_en_send: got %b required 1", lines_enable);
        end
      end
      done = 1'b0; cnt = 0; g = 0;
      while (!done && g < 400) begin
        g++; cnt++;
        if ((cnt % period) == 0 && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checks++;
          if (inp_data !== e[7:0] || fin_rqst !== e[8]) begin
            errors++;
            $display("FAIL lane_byte: got %h/fin=%b required %h/fin=%b", inp_data, fin_rqst, e[7:0], e[8]);
          end
          data_rqst = 1'b1;
          pushed = 1'b0;
          if (e[8]) begin
            done = 1'b1;
            if (push_en && p == 0) begin
              s_valid = 1'b1;
              {s_lp, s_last, s_data} = push_ent;
              pushed = 1'b1;
            end
          end
          @(negedge clk_sys);
          data_rqst = 1'b0;
          if (pushed) begin
            s_valid = 1'b0;
            exp_q.push_back(push_ent);
          end
        end else begin
          @(negedge clk_sys);
        end
      end
      if (!done) begin
        checks++; errors++;
        $display("FAIL lane_timeout: last byte not consumed, remaining=%0d required 0", exp_q.size());
        return;
      end
      checks++;
      if (fin_rqst !== 1'b1 || inp_data !== 8'h00 || busy !== 1'b1 ||
          start_rqst !== 1'b0 || lines_enable !== 1'b1) begin
        errors++;
        $display("FAIL drain_outputs: fin=%b data=%h busy=%b start=%b len=%b required 1/00/1/0/1",
                 fin_rqst, inp_data, busy, start_rqst, lines_enable);
      end
      data_rqst = 1'b1;
      @(negedge clk_sys);
      data_rqst = 1'b0;
      @(negedge clk_sys);
      active = 1'b0;
      @(negedge clk_sys);
      checks++;
      if (busy !== 1'b0 || start_rqst !== 1'b0 || lines_enable !== enable) begin
        errors++;
        $display("FAIL drain_exit: busy=%b start=%b lines_enable=%b required 0/0/%b",
                 busy, start_rqst, lines_enable, enable);
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({start_rqst, fin_rqst, inp_data, mode_lp, lines_enable, busy, underflow_err, s_ready}
        !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_values: start=%b fin=%b data=%h mode=%b len=%b busy=%b uf=%b rdy=%b",
               start_rqst, fin_rqst, inp_data, mode_lp, lines_enable, busy, underflow_err, s_ready);
    end
  endtask

  task automatic test_lp_packet();
    enable = 1'b0;
    push_byte(1'b1, 1'b0, 8'h11);
    push_byte(1'b1, 1'b0, 8'h22);
    push_byte(1'b1, 1'b1, 8'h33);
    enable = 1'b1;
    serve(1, 4, 1'b0, 10'h000, 1'b0);
    enable = 1'b0;
  endtask

  task automatic test_underflow();
    int g;
    logic lp0;
    logic [9:0] e;
    lp0 = 1'($urandom);
    enable = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(lp0, 1'b0, 8'($urandom));
    checks++;
    if (s_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: s_ready=%b required 0", s_ready);
    end
    g = 0;
    while (start_rqst !== 1'b1 && g < 20) begin
      @(negedge clk_sys);
      g++;
    end
    checks++;
    if (start_rqst !== 1'b1 || mode_lp !== lp0) begin
      errors++;
      $display("FAIL cut_through: start=%b mode=%b required 1/%b", start_rqst, mode_lp, lp0);
    end
    active = 1'b1;
    @(negedge clk_sys);
    for (int i = 0; i < 16; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3ff;
      checks++;
      if (inp_data !== e[7:0] || fin_rqst !== 1'b0) begin
        errors++;
        $display("FAIL ct_byte%0d: got %h/fin=%b required %h/fin=0", i, inp_data, fin_rqst, e[7:0]);
      end
      data_rqst = 1'b1;
      @(negedge clk_sys);
      data_rqst = 1'b0;
      @(negedge clk_sys);
    end
    data_rqst = 1'b1;
    @(negedge clk_sys);
    data_rqst = 1'b0;
    checks++;
    if (underflow_err !== 1'b1 || inp_data !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL underflow: uf=%b data=%h busy=%b required 1/00/1", underflow_err, inp_data, busy);
    end
    data_rqst = 1'b1; err_clr = 1'b1;
    @(negedge clk_sys);
    data_rqst = 1'b0; err_clr = 1'b0;
    checks++;
    if (underflow_err !== 1'b1) begin
      errors++;
      $display("FAIL uf_clr_collide: uf=%b required 1", underflow_err);
    end
    err_clr = 1'b1;
    @(negedge clk_sys);
    err_clr = 1'b0;
    checks++;
    if (underflow_err !== 1'b0) begin
      errors++;
      $display("FAIL uf_clear: uf=%b required 0", underflow_err);
    end
    active = 1'b0; enable = 1'b0;
    do_reset();
  endtask

  task automatic test_back_to_back();
    enable = 1'b0;
    push_pkt(1'b0, int'($urandom_range(1, 4)));
    push_pkt(1'b0, int'($urandom_range(1, 4)));
    enable = 1'b1;
    serve(2, int'($urandom_range(1, 4)), 1'b0, 10'h000, 1'b0);
    enable = 1'b0;
  endtask

  task automatic test_same_cycle_last();
    logic lpb;
    lpb = 1'($urandom);
    enable = 1'b0;
    push_pkt(1'($urandom), 2);
    push_byte(lpb, 1'b0, 8'($urandom));
    enable = 1'b1;
    serve(2, 2, 1'b1, {lpb, 1'b1, 8'($urandom)}, 1'b0);
    enable = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL same_cycle_left: remaining=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_enable_drop();
    bit bad;
    enable = 1'b0;
    push_pkt(1'($urandom), 3);
    push_pkt(1'($urandom), 2);
    enable = 1'b1;
    serve(1, 2, 1'b0, 10'h000, 1'b1);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk_sys);
      if (start_rqst !== 1'b0 || lines_enable !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL disabled_idle: start=%b len=%b busy=%b required 0/0/0", start_rqst, lines_enable, busy);
    end
    enable = 1'b1;
    serve(1, 3, 1'b0, 10'h000, 1'b0);
    enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    int g;
    bit bad;
    enable = 1'b0;
    push_pkt(1'b1, 7);
    enable = 1'b1;
    g = 0;
    while (start_rqst !== 1'b1 && g < 20) begin
      @(negedge clk_sys);
      g++;
    end
    active = 1'b1;
    @(negedge clk_sys);
    data_rqst = 1'b1;
    repeat (2) @(negedge clk_sys);
    data_rqst = 1'b0;
    rst_n = 1'b0; enable = 1'b0; active = 1'b0;
    #1;
    checks++;
    if ({start_rqst, fin_rqst, inp_data, mode_lp, lines_enable, busy, underflow_err, s_ready}
        !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL mid_reset: start=%b fin=%b data=%h mode=%b len=%b busy=%b uf=%b rdy=%b",
               start_rqst, fin_rqst, inp_data, mode_lp, lines_enable, busy, underflow_err, s_ready);
    end
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;
    exp_q.delete();
    enable = 1'b1;
    bad = 1'b0;
    repeat (30) begin
      @(negedge clk_sys);
      if (start_rqst !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL post_reset_start: start=%b busy=%b required 0/0", start_rqst, busy);
    end
    enable = 1'b0;
  endtask

  task automatic test_random();
    int npk;
    for (int it = 0; it < 4; it++) begin
      npk = int'($urandom_range(1, 3));
      enable = 1'b0;
      for (int k = 0; k < npk; k++) push_pkt(1'($urandom), int'($urandom_range(1, 4)));
      enable = 1'b1;
      serve(npk, int'($urandom_range(1, 5)), 1'b0, 10'h000, 1'b0);
      enable = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL random_left: remaining=%0d required 0", exp_q.size());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
    s_lp = 1'b0; data_rqst = 1'b0; active = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk_sys);
    rst_n = 1'b1;
    @(negedge clk_sys);
    test_reset();
    test_lp_packet();
    test_underflow();
    test_back_to_back();
    test_same_cycle_last();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
